imm_gen_pipe: RTL and testbench
===============================

Name: imm_gen_pipe

Overview:
- Parametrised, pipelined immediate generator for the decode stage.
- Covers every RV32I/RV64I immediate format: I, S, B, U, J, shift-amount and CSR.
- Also computes the PC-relative target for branch, JAL and AUIPC, and flags illegal opcodes and misaligned targets.
- Registered output with valid/ready handshake and a one-entry skid buffer, so the IF/ID handshake sees full throughput and no combinational ready path.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Immediates are sign-extended to XLEN.
- RV64, 0, when 1, accept OP-IMM-32 (0011011) and use a 6-bit shamt. Requires XLEN=64.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  upstream holds inst/pc valid
- in_ready  out  1  block can accept this cycle
- inst  in  32  instruction word
- pc  in  XLEN  address of inst
- out_valid  out  1  output bundle valid
- out_ready  in  1  downstream accepts bundle
- imm  out  XLEN  extended immediate
- fmt  out  3  0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 SH, 7 CSR
- target  out  XLEN  pc+imm, modulo 2^XLEN
- target_valid  out  1  target meaningful (B, J, AUIPC)
- misalign  out  1  target_valid and target[1] set
- illegal  out  1  opcode not recognised

Behaviour:
- Decode by inst[6:0]:
  - 1101111 J: {inst[31],inst[19:12],inst[20],inst[30:21],0}, sign-extended.
  - 1100011 B: {inst[31],inst[7],inst[30:25],inst[11:8],0}, sign-extended.
  - 0000011, 1100111 I: inst[31:20], sign-extended.
  - 0100011 S: {inst[31:25],inst[11:7]}, sign-extended.
  - 0110111 LUI, 0010111 AUIPC U: {inst[31:12],12'b0}, sign-extended to XLEN.
  - 0010011 OP-IMM, funct3 001/101: fmt SH, imm = zero-extended shamt. Shamt is inst[24:20], or inst[25:20] when RV64. All other funct3: fmt I.
  - 0011011: when RV64, same as OP-IMM but shamt is always inst[24:20]. When RV64=0: illegal.
  - 1110011: fmt CSR, imm = zero-extended inst[31:20].
  - 0110011, 0001111: fmt NONE, imm 0, legal.
  - Any other opcode: fmt NONE, imm 0, illegal=1.
- target = pc+imm, truncated to XLEN. target_valid=1 only for B, J and AUIPC. JALR gives target_valid=0. When target_valid=0, target is 0.
- Latency: exactly 1 cycle from accept to out_valid when the output register is free.
- Handshake:
  - in_ready = !skid_valid && !rst.
  - Accept when in_valid && in_ready.
  - Output register loads when it is empty or out_ready is high. It takes skid contents first, otherwise the new accept.
  - An accept while out_valid && !out_ready goes to the skid buffer.
  - When out_ready && skid_valid, skid moves to output, skid empties, in_ready returns high the next cycle.
  - Accept plus drain in the same cycle with the skid empty: output reloads with new data, no bubble.
- Outputs hold stable while out_valid && !out_ready.
- Reset (any cycle, including mid-stall):
  - out_valid=0, skid empty, imm/target/fmt/flags=0, in_ready=0.
  - In-flight data is discarded.
  - in_ready=1 on the first cycle after rst deasserts.
- Ordering is strict FIFO; no reordering or duplication.

Test Plan:
- JAL, XLEN=32: inst=0xFFDFF0EF, pc=0x100 -> imm=0xFFFFFFFC, fmt=5, target=0x000000FC, target_valid=1, misalign=0, out_valid one cycle after accept.
- BEQ and SW: inst=0x00000463, pc=0x200 -> imm=8, fmt=3, target=0x208. Then inst=0xFE20AE23 -> imm=0xFFFFFFFC, fmt=2, target_valid=0.
- LUI and SRAI: 0x123452B7 -> imm=0x12345000, fmt=4, target_valid=0. 0x4030D093 -> fmt=6, imm=3. Illegal opcode 0x0000007F -> illegal=1, imm=0.
- Backpressure:
  - Stream 4 instructions with out_ready=0 for 3 cycles.
  - in_ready must drop after 2 accepts and outputs must hold.
  - Releasing out_ready delivers all 4 in order with no loss.
  - Back-to-back throughput then reaches 1 per cycle.
- Reset mid-operation: assert rst while output and skid are both full. Next cycle out_valid=0 and in_ready=0. After deassert, in_ready=1 and no stale data appears.
- XLEN=64, RV64=1:
  - Wrap-around: pc=0xFFFFFFFFFFFFFFFC, AUIPC 0x00001017 -> target=0x0000000000000FFC.
  - slli x1,x1,40 (0x02809093) -> imm=40.
  - OP-IMM-32 (0x0000101B) -> legal, fmt=6. The same opcode with RV64=0 -> illegal=1.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V immediate generator for the decode stage.
// One registered output stage backed by a single-entry skid buffer.
module imm_gen_pipe #(
  parameter int XLEN = 32,
  parameter int RV64 = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] imm,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] target,
  output logic            target_valid,
  output logic            misalign,
  output logic            illegal
);

  typedef enum logic [2:0] {
    FMT_NONE = 3'd0,
    FMT_I    = 3'd1,
    FMT_S    = 3'd2,
    FMT_B    = 3'd3,
    FMT_U    = 3'd4,
    FMT_J    = 3'd5,
    FMT_SH   = 3'd6,
    FMT_CSR  = 3'd7
  } fmt_e;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;

  typedef struct packed {
    logic [XLEN-1:0] imm;
    fmt_e            fmt;
    logic [XLEN-1:0] target;
    logic            target_valid;
    logic            misalign;
    logic            illegal;
  } bundle_t;

  bundle_t dec;
  bundle_t out_q, out_d;
  bundle_t skid_q, skid_d;
  logic    out_valid_q, out_valid_d;
  logic    skid_valid_q, skid_valid_d;

  logic [2:0]      funct3;
  logic            is_shift;
  logic [5:0]      shamt;
  logic [XLEN-1:0] sum;
  logic            accept;
  logic            out_load;

  assign funct3   = inst[14:12];
  assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
  assign shamt    = (RV64 != 0) ? inst[25:20] : {1'b0, inst[24:20]};

  always_comb begin
    dec = '0;
    sum = '0;
    case (inst[6:0])
      OP_JAL: begin
        dec.fmt          = FMT_J;
        dec.imm          = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
        dec.target_valid = 1'b1;
      end
      OP_BRANCH: begin
        dec.fmt          = FMT_B;
        dec.imm          = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
        dec.target_valid = 1'b1;
      end
      OP_LOAD, OP_JALR: begin
        dec.fmt = FMT_I;
        dec.imm = XLEN'($signed(inst[31:20]));
      end
      OP_STORE: begin
        dec.fmt = FMT_S;
        dec.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
      end
      OP_LUI, OP_AUIPC: begin
        dec.fmt          = FMT_U;
        dec.imm          = XLEN'($signed({inst[31:12], 12'b0}));
        dec.target_valid = (inst[6:0] == OP_AUIPC);
      end
      OP_IMM: begin
        if (is_shift) begin
          dec.fmt = FMT_SH;
          dec.imm = XLEN'(shamt);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(inst[31:20]));
        end
      end
      OP_IMM32: begin
        // Word-sized shifts only ever take a 5-bit shamt.
        if (RV64 == 0) begin
          dec.illegal = 1'b1;
        end else if (is_shift) begin
          dec.fmt = FMT_SH;
          dec.imm = XLEN'(inst[24:20]);
        end else begin
          dec.fmt = FMT_I;
          dec.imm = XLEN'($signed(inst[31:20]));
        end
      end
      OP_SYSTEM: begin
        dec.fmt = FMT_CSR;
        dec.imm = XLEN'(inst[31:20]);
      end
      OP_OP, OP_FENCE: begin
        dec.fmt = FMT_NONE;
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase
    if (dec.target_valid) begin
      sum          = pc + dec.imm;
      dec.target   = sum;
      dec.misalign = sum[1];
    end
  end

  assign in_ready = !skid_valid_q && !rst;
  assign accept   = in_valid && in_ready;
  assign out_load = !out_valid_q || out_ready;

  // The skid entry always drains before a new accept can reach the output.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (out_load) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = dec;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign imm          = out_q.imm;
  assign fmt          = out_q.fmt;
  assign target       = out_q.target;
  assign target_valid = out_q.target_valid;
  assign misalign     = out_q.misalign;
  assign illegal      = out_q.illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: one RV32 instance and one RV64 instance.
// Expected bundles are queued on accept and compared whenever out_valid is high.
module tb_imm_gen_pipe;

  typedef struct {
    logic [31:0] imm;
    logic [2:0]  fmt;
    logic [31:0] target;
    logic        tv;
    logic        mis;
    logic        ill;
  } exp32_t;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    exp32_t      e;
  } vec32_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic [63:0] target;
    logic        tv;
    logic        mis;
    logic        ill;
  } exp64_t;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] pc;
    exp64_t      e;
  } vec64_t;

  logic clk;
  logic rst;

  logic        in_valid32, in_ready32, out_valid32, out_ready32;
  logic [31:0] inst32, pc32, imm32, target32;
  logic [2:0]  fmt32;
  logic        tv32, mis32, ill32;

  logic        in_valid64, in_ready64, out_valid64, out_ready64;
  logic [31:0] inst64;
  logic [63:0] pc64, imm64, target64;
  logic [2:0]  fmt64;
  logic        tv64, mis64, ill64;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  exp32_t sb32[$];
  exp64_t sb64[$];
  exp32_t m32;
  exp64_t m64;
  vec32_t tab32[16];
  vec64_t tab64[9];

  imm_gen_pipe #(.XLEN(32), .RV64(0)) dut32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .inst(inst32), .pc(pc32),
    .out_valid(out_valid32), .out_ready(out_ready32),
    .imm(imm32), .fmt(fmt32), .target(target32),
    .target_valid(tv32), .misalign(mis32), .illegal(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .RV64(1)) dut64 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .inst(inst64), .pc(pc64),
    .out_valid(out_valid64), .out_ready(out_ready64),
    .imm(imm64), .fmt(fmt64), .target(target64),
    .target_valid(tv64), .misalign(mis64), .illegal(ill64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  // Scoreboard side: every valid cycle must match the oldest outstanding entry.
  always @(negedge clk) begin
    if (!rst && out_valid32) begin
      n_checks++;
      if (sb32.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL out32_unexpected: got out_valid=1 imm=%h, required no output", imm32);
      end else begin
        m32 = sb32[0];
        if ({imm32, fmt32, target32, tv32, mis32, ill32} !==
            {m32.imm, m32.fmt, m32.target, m32.tv, m32.mis, m32.ill}) begin
          n_fail++;
          $display("[TB] FAIL out32_bundle: got imm=%h fmt=%0d tgt=%h tv=%b mis=%b ill=%b, required imm=%h fmt=%0d tgt=%h tv=%b mis=%b ill=%b",
                   imm32, fmt32, target32, tv32, mis32, ill32,
                   m32.imm, m32.fmt, m32.target, m32.tv, m32.mis, m32.ill);
        end
        if (out_ready32) void'(sb32.pop_front());
      end
    end
    if (!rst && out_valid64) begin
      n_checks++;
      if (sb64.size() == 0) begin
        n_fail++;
        $display("[TB] FAIL out64_unexpected: got out_valid=1 imm=%h, required no output", imm64);
      end else begin
        m64 = sb64[0];
        if ({imm64, fmt64, target64, tv64, mis64, ill64} !==
            {m64.imm, m64.fmt, m64.target, m64.tv, m64.mis, m64.ill}) begin
          n_fail++;
          $display("[TB] FAIL out64_bundle: got imm=%h fmt=%0d tgt=%h tv=%b mis=%b ill=%b, required imm=%h fmt=%0d tgt=%h tv=%b mis=%b ill=%b",
                   imm64, fmt64, target64, tv64, mis64, ill64,
                   m64.imm, m64.fmt, m64.target, m64.tv, m64.mis, m64.ill);
        end
        if (out_ready64) void'(sb64.pop_front());
      end
    end
  end

  function automatic vec32_t mk32(logic [31:0] inst, logic [31:0] pc, logic [31:0] imm,
                                  logic [2:0] fmt, logic [31:0] tgt, logic tv, logic mis, logic ill);
    vec32_t v;
    v.inst = inst; v.pc = pc;
    v.e.imm = imm; v.e.fmt = fmt; v.e.target = tgt;
    v.e.tv = tv; v.e.mis = mis; v.e.ill = ill;
    return v;
  endfunction

  function automatic vec64_t mk64(logic [31:0] inst, logic [63:0] pc, logic [63:0] imm,
                                  logic [2:0] fmt, logic [63:0] tgt, logic tv, logic mis, logic ill);
    vec64_t v;
    v.inst = inst; v.pc = pc;
    v.e.imm = imm; v.e.fmt = fmt; v.e.target = tgt;
    v.e.tv = tv; v.e.mis = mis; v.e.ill = ill;
    return v;
  endfunction

  task automatic send32(input vec32_t v);
    int budget;
    budget = 50;
    inst32 = v.inst; pc32 = v.pc; in_valid32 = 1'b1;
    @(negedge clk);
    while (!in_ready32 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready32) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL accept32_timeout: got in_ready=0 for 50 cycles, required 1");
    end else begin
      sb32.push_back(v.e);
    end
    @(posedge clk); #1;
    in_valid32 = 1'b0;
  endtask

  task automatic send64(input vec64_t v);
    int budget;
    budget = 50;
    inst64 = v.inst; pc64 = v.pc; in_valid64 = 1'b1;
    @(negedge clk);
    while (!in_ready64 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (!in_ready64) begin
      n_checks++; n_fail++;
      $display("[TB] FAIL accept64_timeout: got in_ready=0 for 50 cycles, required 1");
    end else begin
      sb64.push_back(v.e);
    end
    @(posedge clk); #1;
    in_valid64 = 1'b0;
  endtask

  task automatic drain(input string name);
    int budget;
    budget = 100;
    while ((sb32.size() != 0 || sb64.size() != 0) && budget > 0) begin
      @(posedge clk); #2;
      budget--;
    end
    n_checks++;
    if (sb32.size() != 0 || sb64.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL %s_drain: got %0d/%0d entries outstanding, required 0/0", name, sb32.size(), sb64.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if ({in_ready32, out_valid32, imm32, fmt32, target32, tv32, mis32, ill32} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset32_state: got rdy=%b vld=%b imm=%h fmt=%0d tgt=%h flags=%b%b%b, required all 0",
               in_ready32, out_valid32, imm32, fmt32, target32, tv32, mis32, ill32);
    end
    n_checks++;
    if ({in_ready64, out_valid64, imm64, fmt64, target64, tv64, mis64, ill64} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset64_state: got rdy=%b vld=%b imm=%h fmt=%0d tgt=%h flags=%b%b%b, required all 0",
               in_ready64, out_valid64, imm64, fmt64, target64, tv64, mis64, ill64);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if ({in_ready32, in_ready64} !== 2'b11) begin
      n_fail++;
      $display("[TB] FAIL reset_release_ready: got %b%b, required 11", in_ready32, in_ready64);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_jal_latency();
    out_ready32 = 1'b1;
    send32(tab32[0]);
    n_checks++;
    if (out_valid32 !== 1'b1 || imm32 !== 32'hFFFF_FFFC || target32 !== 32'h0000_00FC) begin
      n_fail++;
      $display("[TB] FAIL jal_latency: got vld=%b imm=%h tgt=%h one cycle after accept, required 1 fffffffc 000000fc",
               out_valid32, imm32, target32);
    end
    drain("jal");
  endtask

  task automatic test_formats32();
    out_ready32 = 1'b1;
    for (int i = 1; i < 16; i++) begin
      send32(tab32[i]);
      if ((i % 3) == 0) drain("formats32");
    end
    drain("formats32");
  endtask

  task automatic test_backpressure();
    out_ready32 = 1'b0;
    send32(tab32[1]);
    send32(tab32[2]);
    n_checks++;
    if (in_ready32 !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL bp_ready_drop: got in_ready=%b after 2 stalled accepts, required 0", in_ready32);
    end
    inst32 = tab32[3].inst; pc32 = tab32[3].pc; in_valid32 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready32 !== 1'b0 || out_valid32 !== 1'b1 || imm32 !== 32'h0000_0008) begin
      n_fail++;
      $display("[TB] FAIL bp_hold: got rdy=%b vld=%b imm=%h, required 0 1 00000008", in_ready32, out_valid32, imm32);
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    send32(tab32[3]);
    send32(tab32[4]);
    drain("backpressure");
  endtask

  task automatic test_back_to_back();
    int c0;
    out_ready32 = 1'b1;
    c0 = cyc;
    for (int i = 0; i < 8; i++) send32(tab32[i]);
    n_checks++;
    if (cyc - c0 != 8) begin
      n_fail++;
      $display("[TB] FAIL b2b_throughput: got %0d cycles for 8 accepts, required 8", cyc - c0);
    end
    drain("b2b");
  endtask

  task automatic test_reset_mid();
    out_ready32 = 1'b0;
    send32(tab32[6]);
    send32(tab32[7]);
    rst = 1'b1;
    sb32.delete();
    @(posedge clk); #1;
    n_checks++;
    if (out_valid32 !== 1'b0 || in_ready32 !== 1'b0 || imm32 !== 32'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_state: got vld=%b rdy=%b imm=%h, required 0 0 00000000", out_valid32, in_ready32, imm32);
    end
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready32 !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL reset_mid_ready: got in_ready=%b after release, required 1", in_ready32);
    end
    out_ready32 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid32 !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL reset_mid_stale: got out_valid=1 imm=%h in cycle %0d after reset, required 0", imm32, i);
      end
    end
  endtask

  task automatic test_rv64();
    out_ready64 = 1'b1;
    for (int i = 0; i < 9; i++) send64(tab64[i]);
    drain("rv64");
  endtask

  initial begin
    rst = 1'b1;
    in_valid32 = 1'b0; inst32 = '0; pc32 = '0; out_ready32 = 1'b0;
    in_valid64 = 1'b0; inst64 = '0; pc64 = '0; out_ready64 = 1'b0;

    tab32[0]  = mk32(32'hFFDFF0EF, 32'h100, 32'hFFFF_FFFC, 3'd5, 32'h0000_00FC, 1, 0, 0);
    tab32[1]  = mk32(32'h00000463, 32'h200, 32'h0000_0008, 3'd3, 32'h0000_0208, 1, 0, 0);
    tab32[2]  = mk32(32'hFE20AE23, 32'h204, 32'hFFFF_FFFC, 3'd2, 32'h0,        0, 0, 0);
    tab32[3]  = mk32(32'h123452B7, 32'h208, 32'h1234_5000, 3'd4, 32'h0,        0, 0, 0);
    tab32[4]  = mk32(32'h4030D093, 32'h20C, 32'h0000_0003, 3'd6, 32'h0,        0, 0, 0);
    tab32[5]  = mk32(32'h0000007F, 32'h210, 32'h0,         3'd0, 32'h0,        0, 0, 1);
    tab32[6]  = mk32(32'hFFC12083, 32'h214, 32'hFFFF_FFFC, 3'd1, 32'h0,        0, 0, 0);
    tab32[7]  = mk32(32'h300110F3, 32'h218, 32'h0000_0300, 3'd7, 32'h0,        0, 0, 0);
    tab32[8]  = mk32(32'h00008067, 32'h21C, 32'h0,         3'd1, 32'h0,        0, 0, 0);
    tab32[9]  = mk32(32'h002081B3, 32'h220, 32'h0,         3'd0, 32'h0,        0, 0, 0);
    tab32[10] = mk32(32'h0000000F, 32'h224, 32'h0,         3'd0, 32'h0,        0, 0, 0);
    tab32[11] = mk32(32'h00000163, 32'h200, 32'h0000_0002, 3'd3, 32'h0000_0202, 1, 1, 0);
    tab32[12] = mk32(32'h00001017, 32'h010, 32'h0000_1000, 3'd4, 32'h0000_1010, 1, 0, 0);
    tab32[13] = mk32(32'h0000101B, 32'h228, 32'h0,         3'd0, 32'h0,        0, 0, 1);
    tab32[14] = mk32(32'hFFF00093, 32'h22C, 32'hFFFF_FFFF, 3'd1, 32'h0,        0, 0, 0);
    tab32[15] = mk32(32'h02109093, 32'h230, 32'h0000_0001, 3'd6, 32'h0,        0, 0, 0);

    tab64[0] = mk64(32'h00001017, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1000, 3'd4, 64'h0FFC, 1, 0, 0);
    tab64[1] = mk64(32'h02809093, 64'h100, 64'd40, 3'd6, 64'h0, 0, 0, 0);
    tab64[2] = mk64(32'h0000101B, 64'h104, 64'd0,  3'd6, 64'h0, 0, 0, 0);
    tab64[3] = mk64(32'h0210109B, 64'h108, 64'd1,  3'd6, 64'h0, 0, 0, 0);
    tab64[4] = mk64(32'h800002B7, 64'h10C, 64'hFFFF_FFFF_8000_0000, 3'd4, 64'h0, 0, 0, 0);
    tab64[5] = mk64(32'hFFDFF0EF, 64'h100, 64'hFFFF_FFFF_FFFF_FFFC, 3'd5, 64'hFC, 1, 0, 0);
    tab64[6] = mk64(32'h43F0D093, 64'h110, 64'd63, 3'd6, 64'h0, 0, 0, 0);
    tab64[7] = mk64(32'h0000007F, 64'h114, 64'd0,  3'd0, 64'h0, 0, 0, 1);
    tab64[8] = mk64(32'hFFF0809B, 64'h118, 64'hFFFF_FFFF_FFFF_FFFF, 3'd1, 64'h0, 0, 0, 0);

    test_reset();
    test_jal_latency();
    test_formats32();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_rv64();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
